// File: rtl/regfile_access_controller.sv
// regfile_access_controller
// Initiator-side sequencer for a 32-entry multi-ported register file.
// It accepts one request (up to 4 reads, up to 2 writes) on a valid/ready
// handshake and encodes it into one or two register-file operation codes.
// Read results come from the file's output latches and are returned on a
// valid/ready response channel.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_*                    request bundle (counts, indices, write data)
//   resp_*                   response channel (valid/ready, error, read data)
//   rf_ctrl, rf_port1..4     registered register-file control code and ports
//   rf_latch1..4             register-file output latches
//   op_count                 (only with RFC_OP_CNT_EN) count of non-NOP cycles
//
// Optional build macro: RFC_OP_CNT_EN adds the op_count output and counter.
module regfile_access_controller #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_rd_cnt,
  input  logic [ADDR_W-1:0] req_rd_addr0,
  input  logic [ADDR_W-1:0] req_rd_addr1,
  input  logic [ADDR_W-1:0] req_rd_addr2,
  input  logic [ADDR_W-1:0] req_rd_addr3,
  input  logic [1:0]        req_wr_cnt,
  input  logic [ADDR_W-1:0] req_wr_addr0,
  input  logic [ADDR_W-1:0] req_wr_addr1,
  input  logic [DATA_W-1:0] req_wr_data0,
  input  logic [DATA_W-1:0] req_wr_data1,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rd_data0,
  output logic [DATA_W-1:0] resp_rd_data1,
  output logic [DATA_W-1:0] resp_rd_data2,
  output logic [DATA_W-1:0] resp_rd_data3,
  output logic [3:0]        rf_ctrl,
  output logic [DATA_W-1:0] rf_port1,
  output logic [DATA_W-1:0] rf_port2,
  output logic [DATA_W-1:0] rf_port3,
  output logic [DATA_W-1:0] rf_port4,
  input  logic [DATA_W-1:0] rf_latch1,
  input  logic [DATA_W-1:0] rf_latch2,
  input  logic [DATA_W-1:0] rf_latch3,
  input  logic [DATA_W-1:0] rf_latch4
`ifdef RFC_OP_CNT_EN
  ,
  output logic [31:0]       op_count
`endif
);

  localparam logic [3:0] NOP = 4'hF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE_A = 3'd1,
    WAIT_A  = 3'd2,
    ISSUE_B = 3'd3,
    RESP    = 3'd4
  } state_t;

  function automatic logic [DATA_W-1:0] zext(input logic [ADDR_W-1:0] a);
    return {{(DATA_W-ADDR_W){1'b0}}, a};
  endfunction

  state_t            state_r;
  logic [2:0]        rd_cnt_r;
  logic              two_r;
  logic [3:0]        code_b_r;
  logic [DATA_W-1:0] pb_r      [4];
  logic [DATA_W-1:0] port_r    [4];
  logic [DATA_W-1:0] rd_data_r [4];

  logic              bad_s;
  logic              empty_s;
  logic              two_s;
  logic [3:0]        code_a_s;
  logic [3:0]        code_b_s;
  logic [DATA_W-1:0] pa_s      [4];
  logic [DATA_W-1:0] pb_s      [4];
  logic [DATA_W-1:0] rd_addr_s [4];
  logic [DATA_W-1:0] latch_s   [4];

  // Zero-extended read indices and latch inputs gathered into arrays.
  always_comb begin
    rd_addr_s[0] = zext(req_rd_addr0);
    rd_addr_s[1] = zext(req_rd_addr1);
    rd_addr_s[2] = zext(req_rd_addr2);
    rd_addr_s[3] = zext(req_rd_addr3);
    latch_s[0]   = rf_latch1;
    latch_s[1]   = rf_latch2;
    latch_s[2]   = rf_latch3;
    latch_s[3]   = rf_latch4;
  end

  // Encode the live request into phase A (and optional phase B) code/ports.
  always_comb begin
    bad_s    = (req_rd_cnt > 3'd4) || (req_wr_cnt == 2'd3);
    empty_s  = (req_rd_cnt == 3'd0) && (req_wr_cnt == 2'd0);
    two_s    = 1'b0;
    code_a_s = NOP;
    code_b_s = NOP;
    for (int i = 0; i < 4; i++) begin
      pa_s[i] = '0;
      pb_s[i] = '0;
    end
    if (!bad_s && !empty_s) begin
      case ({req_rd_cnt, req_wr_cnt})
        {3'd1, 2'd1}: begin
          code_a_s = 4'd4;
          pa_s[0]  = rd_addr_s[0];
          pa_s[1]  = req_wr_data0;
          pa_s[2]  = zext(req_wr_addr0);
        end
        {3'd2, 2'd1}: begin
          code_a_s = 4'd5;
          pa_s[0]  = rd_addr_s[0];
          pa_s[1]  = rd_addr_s[1];
          pa_s[2]  = req_wr_data0;
          pa_s[3]  = zext(req_wr_addr0);
        end
        {3'd0, 2'd1}: begin
          code_a_s = 4'd6;
          pa_s[0]  = zext(req_wr_addr0);
          pa_s[1]  = req_wr_data0;
        end
        {3'd0, 2'd2}: begin
          code_a_s = 4'd7;
          pa_s[0]  = zext(req_wr_addr0);
          pa_s[1]  = req_wr_data0;
          pa_s[2]  = zext(req_wr_addr1);
          pa_s[3]  = req_wr_data1;
        end
        default: begin
          // Read-only code r-1 (r is 1..4 here; 4 wraps to 3 in two bits).
          code_a_s = {2'b00, req_rd_cnt[1:0] - 2'd1};
          for (int i = 0; i < 4; i++) begin
            if (3'(i) < req_rd_cnt) begin
              pa_s[i] = rd_addr_s[i];
            end else begin
              pa_s[i] = '0;
            end
          end
          // Any writes left over go to a second, write-only phase.
          if (req_wr_cnt != 2'd0) begin
            two_s    = 1'b1;
            code_b_s = (req_wr_cnt == 2'd1) ? 4'd6 : 4'd7;
            pb_s[0]  = zext(req_wr_addr0);
            pb_s[1]  = req_wr_data0;
            if (req_wr_cnt == 2'd2) begin
              pb_s[2] = zext(req_wr_addr1);
              pb_s[3] = req_wr_data1;
            end else begin
              pb_s[2] = '0;
              pb_s[3] = '0;
            end
          end else begin
            two_s = 1'b0;
          end
        end
      endcase
    end else begin
      code_a_s = NOP;
    end
  end

  // Sequencer FSM with all handshake and register-file outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      rf_ctrl    <= NOP;
      rd_cnt_r   <= 3'd0;
      two_r      <= 1'b0;
      code_b_r   <= NOP;
      for (int i = 0; i < 4; i++) begin
        port_r[i]    <= '0;
        pb_r[i]      <= '0;
        rd_data_r[i] <= '0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            rd_cnt_r  <= req_rd_cnt;
            two_r     <= two_s;
            code_b_r  <= code_b_s;
            resp_err  <= bad_s;
            for (int i = 0; i < 4; i++) begin
              pb_r[i]      <= pb_s[i];
              rd_data_r[i] <= '0;
            end
            if (bad_s || empty_s) begin
              state_r    <= RESP;
              resp_valid <= 1'b1;
            end else begin
              state_r <= ISSUE_A;
              rf_ctrl <= code_a_s;
              for (int i = 0; i < 4; i++) begin
                port_r[i] <= pa_s[i];
              end
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE_A: begin
          state_r <= WAIT_A;
          rf_ctrl <= NOP;
          for (int i = 0; i < 4; i++) begin
            port_r[i] <= '0;
          end
        end
        WAIT_A: begin
          // Latches now hold the phase A reads (pre-write values).
          for (int i = 0; i < 4; i++) begin
            if (3'(i) < rd_cnt_r) begin
              rd_data_r[i] <= latch_s[i];
            end else begin
              rd_data_r[i] <= '0;
            end
          end
          if (two_r) begin
            state_r <= ISSUE_B;
            rf_ctrl <= code_b_r;
            for (int i = 0; i < 4; i++) begin
              port_r[i] <= pb_r[i];
            end
          end else begin
            state_r    <= RESP;
            resp_valid <= 1'b1;
          end
        end
        ISSUE_B: begin
          state_r    <= RESP;
          resp_valid <= 1'b1;
          rf_ctrl    <= NOP;
          for (int i = 0; i < 4; i++) begin
            port_r[i] <= '0;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_r    <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          state_r    <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          rf_ctrl    <= NOP;
        end
      endcase
    end
  end

  assign rf_port1      = port_r[0];
  assign rf_port2      = port_r[1];
  assign rf_port3      = port_r[2];
  assign rf_port4      = port_r[3];
  assign resp_rd_data0 = rd_data_r[0];
  assign resp_rd_data1 = rd_data_r[1];
  assign resp_rd_data2 = rd_data_r[2];
  assign resp_rd_data3 = rd_data_r[3];

`ifdef RFC_OP_CNT_EN
  // Count every cycle in which a real operation code is driven.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= 32'd0;
    end else if (rf_ctrl != NOP) begin
      op_count <= op_count + 32'd1;
    end else begin
      op_count <= op_count;
    end
  end
`endif

endmodule
